dwt_window_feeder: RTL and testbench
====================================

Name: dwt_window_feeder

Overview:
- Upstream neighbour of the 6-tap DWT processing element (PE).
- Accepts a row-serial stream of FP32 samples with a valid/ready handshake and builds 6-sample sliding windows at stride 2 (dyadic decimation), with zero padding at row boundaries.
- Drives the PE's six data inputs. Carries a valid/last tag through a delay line matched to the PE pipeline, so downstream logic knows when the PE's data_out is meaningful.

Parameters:
- DATA_WIDTH, 32, sample width (FP32 bit pattern; never interpreted arithmetically here).
- PE_LATENCY, 4, cycles from window presentation at the PE inputs to the matching PE data_out; must be ≥1.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream sample valid.
- in_ready  out  1  block can accept a sample this cycle.
- in_data  in  DATA_WIDTH  input sample.
- in_last  in  1  qualifies the last sample of a row (sampled with in_valid&&in_ready).
- win_valid  out  1  one-cycle pulse; win_data1..6 hold a new window.
- win_last  out  1  with win_valid; last window of the row.
- win_data1 .. win_data6  out  DATA_WIDTH each  window taps; 1 = oldest, 6 = newest; connect to PE data_in1..6.
- pe_valid  out  1  win_valid delayed by PE_LATENCY cycles.
- pe_last  out  1  win_last delayed by PE_LATENCY cycles.

Behaviour:
- Reset: all outputs 0 (in_ready = 0 during reset); window register, phase bit, flush counter and delay lines cleared; FSM = RUN. in_ready = 1 from the first cycle after reset deasserts.
- Reset mid-row or mid-flush discards all state; no partial windows are emitted.
- Storage: 6-entry shift register sr[0..5], sr[5] newest. A "shift" moves every entry down one place and loads the new value into sr[5].
- FSM RUN:
  - in_ready = 1; accept = in_valid && in_ready.
  - Each accept shifts in in_data and toggles the phase bit.
  - On accept with in_last: record count parity and go to FLUSH.
- FSM FLUSH:
  - in_ready = 0; one zero is shifted per cycle, toggling phase.
  - 4 zeros are inserted if the row length is even, 5 if odd.
  - After the final zero: clear sr to all zeros, phase = 0, return to RUN on the next cycle.
- Window emission:
  - Whenever a shift (sample or zero) leaves phase = 0 (every 2nd shift), the new sr contents are registered to win_data1..6 and win_valid pulses the following cycle.
  - Latency: 1 cycle after the completing accept/shift.
  - win_data holds its value until the next window.
- Window content for a row of N samples x0..x(N-1):
  - Window k (k = 0 .. ceil(N/2)+1) = x[2k-4 .. 2k+1]; indices <0 or ≥N read as 0.
  - Windows per row = ceil((N+4)/2).
  - win_last is asserted on the final window of the row.
- Row start is always zero-padded because sr is cleared at reset and at the end of every flush.
- N = 1 is legal: 5 flush zeros, 3 windows.
- Delay line: a PE_LATENCY-deep shift of {win_valid, win_last} produces {pe_valid, pe_last}. It runs every cycle (the PE has no stall), cleared by rst.
- No back-pressure from the PE. Throughput: 1 sample/cycle in RUN; the flush costs 4–5 cycles per row.
- in_last without in_valid is ignored.
- in_valid held during FLUSH: the sample is not accepted and must stay stable until in_ready = 1.

Decomposition:
- Shared package dwt_pkg:
  - DWT_TAPS = 6
  - default DATA_WIDTH = 32
  - FLUSH_EVEN = 4, FLUSH_ODD = 5
  - typedef enum {RUN, FLUSH} feeder_state_t
- Sub-module dwt_valid_delay (parameter DEPTH, WIDTH), a synchronous-reset shift register used for the pe_valid/pe_last alignment. It is reusable for other DWT stages.

Test Plan:
- Row N=8, samples 1.0..8.0 (0x3F800000..0x41000000), in_valid held high → 6 windows:
  - [0,0,0,0,1,2], [0,0,1,2,3,4], [1..6], [3..8], [5,6,7,8,0,0], [7,8,0,0,0,0]
  - win_last on the 6th; in_ready low exactly 4 cycles after the in_last accept.
- Row N=5 (1.0..5.0) → 5 flush zeros, 5 windows; last window = [5.0,0,0,0,0,0] with win_last; in_ready low 5 cycles.
- Two back-to-back rows (N=4 of 1.0, then N=4 of 2.0) → second row's first window = [0,0,0,0,2.0,2.0]; no 1.0 leaks across the row boundary.
- in_valid toggling every other cycle on N=8 → same 6 windows and values as the first test; each win_valid exactly 1 cycle after the completing accept.
- PE_LATENCY=4: every win_valid pulse reappears on pe_valid exactly 4 cycles later; pe_last aligns with the final window's pe_valid.
- rst asserted for 1 cycle mid-flush → all outputs 0 the next cycle; next row starts with all-zero padding and no stray win_valid/pe_valid.

Source files
------------

// File: rtl/dwt_pkg.sv
// Shared constants and types for the DWT stage blocks.
package dwt_pkg;

    localparam int DWT_TAPS           = 6;
    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int FLUSH_EVEN         = 4;
    localparam int FLUSH_ODD          = 5;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } feeder_state_t;

endpackage

// File: rtl/dwt_window_feeder_if.sv
// Sample-stream, window and PE-tag signals of the DWT window feeder.
interface dwt_window_feeder_if
    import dwt_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) ();

    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_last;

    logic                  win_valid;
    logic                  win_last;
    logic [DATA_WIDTH-1:0] win_data1;
    logic [DATA_WIDTH-1:0] win_data2;
    logic [DATA_WIDTH-1:0] win_data3;
    logic [DATA_WIDTH-1:0] win_data4;
    logic [DATA_WIDTH-1:0] win_data5;
    logic [DATA_WIDTH-1:0] win_data6;

    logic                  pe_valid;
    logic                  pe_last;

    modport slave (
        input  in_valid, in_data, in_last,
        output in_ready,
        output win_valid, win_last,
        output win_data1, win_data2, win_data3, win_data4, win_data5, win_data6,
        output pe_valid, pe_last
    );

    modport master (
        output in_valid, in_data, in_last,
        input  in_ready,
        input  win_valid, win_last,
        input  win_data1, win_data2, win_data3, win_data4, win_data5, win_data6,
        input  pe_valid, pe_last
    );

endinterface

// File: rtl/dwt_valid_delay.sv
// Fixed-depth, synchronously reset shift register for aligning tags with a pipeline.
module dwt_valid_delay #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage [DEPTH];

    // Advance the delay line every cycle; reset empties it.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= din;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/dwt_window_feeder.sv
// Builds stride-2, 6-sample zero-padded windows from a row-serial sample stream
// and carries a valid/last tag matched to the PE pipeline latency.
module dwt_window_feeder
    import dwt_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int PE_LATENCY = 4
) (
    input logic                 clk,
    input logic                 rst,
    dwt_window_feeder_if.slave  bus
);

    localparam logic [0:0] ST_RUN   = 1'(RUN);
    localparam logic [0:0] ST_FLUSH = 1'(FLUSH);

    logic [0:0]            state;
    logic [DATA_WIDTH-1:0] sr      [DWT_TAPS];
    logic [DATA_WIDTH-1:0] sr_next [DWT_TAPS];
    logic [DATA_WIDTH-1:0] win     [DWT_TAPS];
    logic                  phase;
    logic [2:0]            flush_left;

    logic                  in_ready;
    logic                  accept;
    logic                  do_shift;
    logic                  emit;
    logic                  final_zero;
    logic [DATA_WIDTH-1:0] shift_val;

    logic                  win_valid;
    logic                  win_last;
    logic [1:0]            pe_tag;

    assign in_ready = (state == ST_RUN) && !rst;

    // Shift source selection and window-completion detection.
    always_comb begin
        accept     = in_ready && bus.in_valid;
        do_shift   = accept || (state == ST_FLUSH);
        shift_val  = accept ? bus.in_data : '0;
        final_zero = (state == ST_FLUSH) && (flush_left == 3'd1);
        // phase = 1 means this shift returns it to 0: a window is complete
        emit       = do_shift && phase;
        for (int unsigned i = 0; i < DWT_TAPS - 1; i++) begin
            sr_next[i] = sr[i+1];
        end
        sr_next[DWT_TAPS-1] = shift_val;
    end

    // Row FSM, sample shift register, phase bit and flush counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_RUN;
            phase      <= 1'b0;
            flush_left <= '0;
            for (int unsigned i = 0; i < DWT_TAPS; i++) begin
                sr[i] <= '0;
            end
        end else if (do_shift) begin
            if (final_zero) begin
                // Clearing here gives the next row its leading zero padding;
                // the window built from the last zero is captured from sr_next.
                state      <= ST_RUN;
                phase      <= 1'b0;
                flush_left <= '0;
                for (int unsigned i = 0; i < DWT_TAPS; i++) begin
                    sr[i] <= '0;
                end
            end else begin
                phase <= ~phase;
                for (int unsigned i = 0; i < DWT_TAPS; i++) begin
                    sr[i] <= sr_next[i];
                end
                if (accept && bus.in_last) begin
                    // phase after this accept equals the row length parity
                    state      <= ST_FLUSH;
                    flush_left <= (~phase) ? 3'(FLUSH_ODD) : 3'(FLUSH_EVEN);
                end else if (state == ST_FLUSH) begin
                    flush_left <= flush_left - 3'd1;
                end
            end
        end
    end

    // Window output register: one-cycle valid pulse, data held until next window.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_valid <= 1'b0;
            win_last  <= 1'b0;
            for (int unsigned i = 0; i < DWT_TAPS; i++) begin
                win[i] <= '0;
            end
        end else begin
            win_valid <= emit;
            win_last  <= emit && final_zero;
            if (emit) begin
                for (int unsigned i = 0; i < DWT_TAPS; i++) begin
                    win[i] <= sr_next[i];
                end
            end
        end
    end

    dwt_valid_delay #(
        .DEPTH (PE_LATENCY),
        .WIDTH (2)
    ) u_pe_delay (
        .clk  (clk),
        .rst  (rst),
        .din  ({win_valid, win_last}),
        .dout (pe_tag)
    );

    assign bus.in_ready  = in_ready;
    assign bus.win_valid = win_valid;
    assign bus.win_last  = win_last;
    assign bus.win_data1 = win[0];
    assign bus.win_data2 = win[1];
    assign bus.win_data3 = win[2];
    assign bus.win_data4 = win[3];
    assign bus.win_data5 = win[4];
    assign bus.win_data6 = win[5];
    assign bus.pe_valid  = pe_tag[1];
    assign bus.pe_last   = pe_tag[0];

endmodule

// File: tb/tb_dwt_window_feeder.sv
// Randomised and directed bench for dwt_window_feeder against a window-index model.
module tb_dwt_window_feeder;
    import dwt_pkg::*;

    localparam int DW  = 32;
    localparam int LAT = 4;

    localparam logic [31:0] F1 = 32'h3F800000;
    localparam logic [31:0] F2 = 32'h40000000;
    localparam logic [31:0] F3 = 32'h40400000;
    localparam logic [31:0] F4 = 32'h40800000;
    localparam logic [31:0] F5 = 32'h40A00000;
    localparam logic [31:0] F6 = 32'h40C00000;
    localparam logic [31:0] F7 = 32'h40E00000;
    localparam logic [31:0] F8 = 32'h41000000;

    typedef struct packed {
        logic [5:0][31:0] d;
        logic             last;
    } win_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dwt_window_feeder_if #(.DATA_WIDTH(DW)) bus ();

    dwt_window_feeder #(
        .DATA_WIDTH (DW),
        .PE_LATENCY (LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks  = 0;
    int errors  = 0;
    int low_cnt = 0;

    logic [31:0] fp [8] = '{F1, F2, F3, F4, F5, F6, F7, F8};

    // Behavioural model: current row samples, shift count, flush bookkeeping
    logic [31:0] row [$];
    int          shifts     = 0;
    bit          flushing   = 1'b0;
    int          flush_left = 0;
    bit          m_acc      = 1'b0;
    bit          m_wv       = 1'b0;
    bit          m_wl       = 1'b0;
    logic [31:0] m_wd [6]   = '{default: '0};
    bit          hv [$];
    bit          hl [$];
    bit          m_pv       = 1'b0;
    bit          m_pl       = 1'b0;
    win_t        wlog [$];

    function automatic logic [31:0] tap(int idx);
        if (idx < 0 || idx >= row.size()) return '0;
        return row[idx];
    endfunction

    // Window k covers x[2k-4 .. 2k+1]; last window index is ceil(N/2)+1
    function automatic void model_emit(int k, int n_final);
        win_t w;
        for (int j = 0; j < 6; j++) begin
            m_wd[j]  = tap(2 * k - 4 + j);
            w.d[j]   = m_wd[j];
        end
        m_wv   = 1'b1;
        m_wl   = (n_final > 0) && (k == (n_final + 1) / 2 + 1);
        w.last = m_wl;
        wlog.push_back(w);
    endfunction

    always @(posedge clk) begin
        bit nv, nl;
        m_acc = 1'b0;
        if (rst) begin
            row.delete();
            shifts = 0; flushing = 1'b0; flush_left = 0;
            m_wv = 1'b0; m_wl = 1'b0;
            for (int j = 0; j < 6; j++) m_wd[j] = '0;
            hv.delete(); hl.delete();
            for (int j = 0; j < LAT; j++) begin hv.push_back(1'b0); hl.push_back(1'b0); end
            m_pv = 1'b0; m_pl = 1'b0;
        end else begin
            m_wv = 1'b0; m_wl = 1'b0;
            if (!flushing) begin
                if (bus.in_valid) begin
                    m_acc = 1'b1;
                    row.push_back(bus.in_data);
                    shifts++;
                    if (shifts % 2 == 0) model_emit(shifts / 2 - 1, 0);
                    if (bus.in_last) begin
                        flushing   = 1'b1;
                        flush_left = (row.size() % 2 == 0) ? FLUSH_EVEN : FLUSH_ODD;
                    end
                end
            end else begin
                shifts++;
                flush_left--;
                if (shifts % 2 == 0) model_emit(shifts / 2 - 1, row.size());
                if (flush_left == 0) begin
                    flushing = 1'b0;
                    row.delete();
                    shifts = 0;
                end
            end
            nv = hv.pop_front();
            nl = hl.pop_front();
            m_pv = nv; m_pl = nl;
            hv.push_back(m_wv);
            hl.push_back(m_wl);
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic check_cycle();
        if (!rst && bus.in_ready === 1'b0) low_cnt++;
        chk("in_ready",  32'(bus.in_ready),  32'(!rst && !flushing));
        chk("win_valid", 32'(bus.win_valid), 32'(m_wv));
        chk("win_last",  32'(bus.win_last),  32'(m_wl));
        chk("pe_valid",  32'(bus.pe_valid),  32'(m_pv));
        chk("pe_last",   32'(bus.pe_last),   32'(m_pl));
        chk("win_data1", bus.win_data1, m_wd[0]);
        chk("win_data2", bus.win_data2, m_wd[1]);
        chk("win_data3", bus.win_data3, m_wd[2]);
        chk("win_data4", bus.win_data4, m_wd[3]);
        chk("win_data5", bus.win_data5, m_wd[4]);
        chk("win_data6", bus.win_data6, m_wd[5]);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        check_cycle();
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) begin
            bus.in_valid = 1'b0;
            bus.in_last  = 1'($urandom_range(0, 1));
            bus.in_data  = $urandom;
            tick();
        end
    endtask

    task automatic send(logic [31:0] d, bit last, int gap);
        int guard;
        idle(gap);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        guard = 0;
        do begin
            tick();
            guard++;
        end while (!m_acc && guard < 40);
        if (!m_acc) chk("accept_timeout", 32'(guard), 32'(0));
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic pin(string nm, int idx, logic [31:0] a0, logic [31:0] a1, logic [31:0] a2,
                       logic [31:0] a3, logic [31:0] a4, logic [31:0] a5, bit last);
        logic [31:0] e [6];
        e = '{a0, a1, a2, a3, a4, a5};
        if (idx >= wlog.size()) begin
            chk({nm, "_missing"}, 32'(wlog.size()), 32'(idx + 1));
            return;
        end
        for (int j = 0; j < 6; j++) chk(nm, wlog[idx].d[j], e[j]);
        chk({nm, "_last"}, 32'(wlog[idx].last), 32'(last));
    endtask

    task automatic row_1_to_8(int gap);
        wlog.delete();
        low_cnt = 0;
        for (int i = 0; i < 8; i++) send(fp[i], i == 7, gap);
        idle(8);
        chk("n8_count", 32'(wlog.size()), 32'd6);
        chk("n8_ready_low", 32'(low_cnt), 32'd4);
        pin("n8_w0", 0, 0, 0, 0, 0, F1, F2, 0);
        pin("n8_w1", 1, 0, 0, F1, F2, F3, F4, 0);
        pin("n8_w2", 2, F1, F2, F3, F4, F5, F6, 0);
        pin("n8_w3", 3, F3, F4, F5, F6, F7, F8, 0);
        pin("n8_w4", 4, F5, F6, F7, F8, 0, 0, 0);
        pin("n8_w5", 5, F7, F8, 0, 0, 0, 0, 1);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_data  = '0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        idle(2);

        // N=8, back-to-back samples
        row_1_to_8(0);

        // N=5: odd length, five flush zeros
        wlog.delete();
        low_cnt = 0;
        for (int i = 0; i < 5; i++) send(fp[i], i == 4, 0);
        idle(8);
        chk("n5_count", 32'(wlog.size()), 32'd5);
        chk("n5_ready_low", 32'(low_cnt), 32'd5);
        pin("n5_w2", 2, F1, F2, F3, F4, F5, 0, 0);
        pin("n5_w4", 4, F5, 0, 0, 0, 0, 0, 1);

        // Two rows back-to-back: no carry-over across the boundary
        wlog.delete();
        for (int i = 0; i < 4; i++) send(F1, i == 3, 0);
        for (int i = 0; i < 4; i++) send(F2, i == 3, 0);
        idle(8);
        chk("b2b_count", 32'(wlog.size()), 32'd8);
        pin("b2b_w3", 3, F1, F1, 0, 0, 0, 0, 1);
        pin("b2b_w4", 4, 0, 0, 0, 0, F2, F2, 0);

        // N=8 with in_valid every other cycle
        row_1_to_8(1);

        // Reset in the middle of a flush
        for (int i = 0; i < 6; i++) send($urandom, i == 5, 0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wlog.delete();
        idle(LAT + 2);
        chk("rst_no_windows", 32'(wlog.size()), 32'd0);
        for (int i = 0; i < 3; i++) send(fp[i], i == 2, 0);
        idle(8);
        chk("rst_count", 32'(wlog.size()), 32'd4);
        pin("rst_w0", 0, 0, 0, 0, 0, F1, F2, 0);
        pin("rst_w3", 3, F3, 0, 0, 0, 0, 0, 1);

        // Random rows, random gaps, random data
        for (int r = 0; r < 25; r++) begin
            int n;
            n = $urandom_range(1, 11);
            for (int i = 0; i < n; i++) send($urandom, i == n - 1, $urandom_range(0, 2));
            if ($urandom_range(0, 2) == 0) idle($urandom_range(0, 6));
        end
        idle(12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
